// File: rtl/sal_bk_timer_if.sv
// BK_TIMING_IF: per-bank timing parameters shared between a timing-table
// producer and the bank timer (consumer). All fields are 8-bit unsigned
// cycle counts.
//   t_rcd : ACT to RD/WR
//   t_rp  : PRE to ACT/REF
//   t_ras : ACT to PRE
//   t_rfc : REF to ACT/REF
//   t_rtp : RD to PRE
//   t_wtp : WR to PRE
interface BK_TIMING_IF;
  logic [7:0] t_rcd;
  logic [7:0] t_rp;
  logic [7:0] t_ras;
  logic [7:0] t_rfc;
  logic [7:0] t_rtp;
  logic [7:0] t_wtp;

  modport consumer (input  t_rcd, t_rp, t_ras, t_rfc, t_rtp, t_wtp);
  modport producer (output t_rcd, t_rp, t_ras, t_rfc, t_rtp, t_wtp);
endinterface

// File: rtl/sal_bk_timer.sv
// sal_bk_timer: single-bank DRAM command timer.
// Tracks bank state (IDLE/ACTIVE/REFRESH), the open row, and five timing
// down-counters, and reports which commands are legal this cycle.
//   clk, rst_n        : clock, asynchronous active-low reset
//   bk_timing_if      : timing parameters, sampled only when a counter loads
//   act_i..ref_i      : single-cycle command strobes
//   row_i             : row address, valid with act_i
//   *_ready_o         : command legal this cycle (from registered state)
//   state_o           : 00 IDLE, 01 ACTIVE, 10 REFRESH
//   row_o             : currently open row
//   err_o             : one-cycle pulse after an illegal command
module sal_bk_timer #(
  parameter int unsigned ROW_W = 14
) (
  input  logic             clk,
  input  logic             rst_n,
  BK_TIMING_IF.consumer    bk_timing_if,
  input  logic             act_i,
  input  logic             rd_i,
  input  logic             wr_i,
  input  logic             pre_i,
  input  logic             ref_i,
  input  logic [ROW_W-1:0] row_i,
  output logic             act_ready_o,
  output logic             rd_ready_o,
  output logic             wr_ready_o,
  output logic             pre_ready_o,
  output logic             ref_ready_o,
  output logic [1:0]       state_o,
  output logic [ROW_W-1:0] row_o,
  output logic             err_o
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'b00,
    S_ACTIVE  = 2'b01,
    S_REFRESH = 2'b10
  } state_e;

  state_e           state_q, state_d;
  logic [7:0]       rcd_cnt_q, rcd_cnt_d;
  logic [7:0]       ras_cnt_q, ras_cnt_d;
  logic [7:0]       rtp_cnt_q, rtp_cnt_d;
  logic [7:0]       rp_cnt_q,  rp_cnt_d;
  logic [7:0]       rfc_cnt_q, rfc_cnt_d;
  logic [ROW_W-1:0] row_q, row_d;
  logic             err_q, err_d;

  logic             legal;
  logic             any_cmd;
  logic [7:0]       rtp_ld, wtp_ld, rfc_ld;

  // A timing value t makes the dependent command ready t cycles later;
  // the load cycle itself counts as one, so load t-1 (0 behaves as 1).
  function automatic logic [7:0] ld_val(input logic [7:0] t);
    return (t == 8'd0) ? 8'd0 : t - 8'd1;
  endfunction

  function automatic logic [7:0] dec(input logic [7:0] c);
    return (c == 8'd0) ? 8'd0 : c - 8'd1;
  endfunction

  assign act_ready_o = (state_q == S_IDLE) && (rp_cnt_q == 8'd0) && (rfc_cnt_q == 8'd0);
  assign ref_ready_o = act_ready_o;
  assign rd_ready_o  = (state_q == S_ACTIVE) && (rcd_cnt_q == 8'd0);
  assign wr_ready_o  = rd_ready_o;
  assign pre_ready_o = (state_q == S_ACTIVE) && (ras_cnt_q == 8'd0) && (rtp_cnt_q == 8'd0);

  assign state_o = state_q;
  assign row_o   = row_q;
  assign err_o   = err_q;

  assign any_cmd = act_i | rd_i | wr_i | pre_i | ref_i;
  assign legal   = $onehot({act_i, rd_i, wr_i, pre_i, ref_i}) &&
                   ((act_i && act_ready_o) || (rd_i  && rd_ready_o) ||
                    (wr_i  && wr_ready_o)  || (pre_i && pre_ready_o) ||
                    (ref_i && ref_ready_o));

  assign rtp_ld = ld_val(bk_timing_if.t_rtp);
  assign wtp_ld = ld_val(bk_timing_if.t_wtp);
  assign rfc_ld = ld_val(bk_timing_if.t_rfc);

  always_comb begin
    state_d   = state_q;
    rcd_cnt_d = dec(rcd_cnt_q);
    ras_cnt_d = dec(ras_cnt_q);
    rtp_cnt_d = dec(rtp_cnt_q);
    rp_cnt_d  = dec(rp_cnt_q);
    rfc_cnt_d = dec(rfc_cnt_q);
    row_d     = row_q;
    err_d     = any_cmd && !legal;

    // Exit refresh on the edge where rfc_cnt reaches 0.
    if (state_q == S_REFRESH && rfc_cnt_q <= 8'd1) begin
      state_d = S_IDLE;
    end

    // Loads override the default decrement assigned above.
    if (legal) begin
      if (act_i) begin
        state_d   = S_ACTIVE;
        rcd_cnt_d = ld_val(bk_timing_if.t_rcd);
        ras_cnt_d = ld_val(bk_timing_if.t_ras);
        row_d     = row_i;
      end else if (rd_i) begin
        rtp_cnt_d = (rtp_cnt_q > rtp_ld) ? rtp_cnt_q : rtp_ld;
      end else if (wr_i) begin
        rtp_cnt_d = (rtp_cnt_q > wtp_ld) ? rtp_cnt_q : wtp_ld;
      end else if (pre_i) begin
        state_d  = S_IDLE;
        rp_cnt_d = ld_val(bk_timing_if.t_rp);
      end else begin
        rfc_cnt_d = rfc_ld;
        state_d   = (rfc_ld != 8'd0) ? S_REFRESH : S_IDLE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      rcd_cnt_q <= '0;
      ras_cnt_q <= '0;
      rtp_cnt_q <= '0;
      rp_cnt_q  <= '0;
      rfc_cnt_q <= '0;
      row_q     <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      rcd_cnt_q <= rcd_cnt_d;
      ras_cnt_q <= ras_cnt_d;
      rtp_cnt_q <= rtp_cnt_d;
      rp_cnt_q  <= rp_cnt_d;
      rfc_cnt_q <= rfc_cnt_d;
      row_q     <= row_d;
      err_q     <= err_d;
    end
  end

endmodule
